// File: rtl/la_uart_pkg.sv
// rtl/la_uart_pkg.sv - shared state encodings and constants for the logic-analyzer UART front end
package la_uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_t;

  typedef enum logic {
    WAIT_HI,
    WAIT_LO
  } pair_state_t;

  localparam logic [15:0] BAUD_921600 = 16'h006C;

endpackage

// File: rtl/UART_tx_cfg_bd.sv
// rtl/UART_tx_cfg_bd.sv - 8N1 serializer with runtime baud divisor and sticky done flag
module UART_tx_cfg_bd
  import la_uart_pkg::*;
#(
  parameter int BAUD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BAUD_W-1:0] baud,
  input  logic              trmt,
  input  logic [7:0]        tx_data,
  output logic              TX,
  output logic              tx_done
);

  localparam logic [BAUD_W-1:0] ONE = BAUD_W'(1);

  tx_state_t         state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_cnt;
  logic [9:0]        shift;
  logic              tick, last, load;

  assign tick = (state == TX_SHIFT) && (baud_cnt == baud - ONE);
  assign last = tick && (bit_cnt == 4'd9);
  assign load = (state == TX_IDLE) && trmt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TX_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE:  if (trmt) state_nxt = TX_SHIFT;
      TX_SHIFT: if (last) state_nxt = TX_IDLE;
      default:  state_nxt = TX_IDLE;
    endcase
  end

  // Ones shift in behind the frame, so TX rests high once all ten bits are out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '1;
      tx_done  <= 1'b0;
    end else if (load) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= {1'b1, tx_data, 1'b0};
      tx_done  <= 1'b0;
    end else if (tick) begin
      baud_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
      shift    <= {1'b1, shift[9:1]};
      if (last) tx_done <= 1'b1;
    end else if (state == TX_SHIFT) begin
      baud_cnt <= baud_cnt + ONE;
    end
  end

  assign TX = shift[0];

endmodule

// File: rtl/uart_rx_cfg_bd.sv
// rtl/uart_rx_cfg_bd.sv - 8N1 deserializer with runtime baud divisor
module uart_rx_cfg_bd
  import la_uart_pkg::*;
#(
  parameter int BAUD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BAUD_W-1:0] baud,
  input  logic              RX,
  output logic [7:0]        rx_byte,
  output logic              rx_byte_vld,
  output logic              frm_err
);

  localparam logic [BAUD_W-1:0] ONE = BAUD_W'(1);

  rx_state_t         state, state_nxt;
  logic              rx_ff1, rx_s, rx_prev;
  logic [BAUD_W-1:0] baud_cnt, target;
  logic [3:0]        bit_cnt;
  logic [7:0]        shift;
  logic              tick, fall;

  // Preset high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_ff1  <= RX;
      rx_s    <= rx_ff1;
      rx_prev <= rx_s;
    end
  end

  assign fall   = rx_prev & ~rx_s;
  assign target = (state == RX_START) ? (baud >> 1) : baud;
  assign tick   = (state != RX_IDLE) && (baud_cnt == target - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    rx_byte_vld = 1'b0;
    frm_err     = 1'b0;
    case (state)
      RX_IDLE:  if (fall) state_nxt = RX_START;
      RX_START: if (tick) state_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_cnt == 4'd7) state_nxt = RX_STOP;
      RX_STOP: begin
        if (tick) begin
          state_nxt   = RX_IDLE;
          rx_byte_vld = rx_s;
          frm_err     = ~rx_s;
        end
      end
      default:  state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      if (state == RX_IDLE || tick) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + ONE;
      if (state != RX_DATA) bit_cnt <= '0;
      else if (tick)        bit_cnt <= bit_cnt + 4'd1;
      if (state == RX_DATA && tick) shift <= {rx_s, shift[7:1]};
    end
  end

  assign rx_byte = shift;

endmodule

// File: rtl/cmd_uart_wrapper.sv
// rtl/cmd_uart_wrapper.sv - pairs host UART bytes into 16-bit commands and sends response bytes
module cmd_uart_wrapper
  import la_uart_pkg::*;
#(
  parameter int BAUD_W    = 16,
  parameter int TMO_BAUDS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BAUD_W-1:0] baud,
  input  logic              RX,
  output logic              TX,
  output logic [15:0]       cmd,
  output logic              cmd_rdy,
  input  logic              clr_cmd_rdy,
  input  logic [7:0]        resp,
  input  logic              send_resp,
  output logic              resp_sent
);

  localparam int TMO_W = BAUD_W + $clog2(TMO_BAUDS) + 1;
  localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

  pair_state_t      state, state_nxt;
  logic [7:0]       rx_byte, hi_byte;
  logic             rx_vld, frm_err, tmo, set_rdy, clr_hi;
  logic [TMO_W-1:0] tmo_cnt, tmo_lim;

  uart_rx_cfg_bd #(.BAUD_W(BAUD_W)) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud        (baud),
    .RX          (RX),
    .rx_byte     (rx_byte),
    .rx_byte_vld (rx_vld),
    .frm_err     (frm_err)
  );

  UART_tx_cfg_bd #(.BAUD_W(BAUD_W)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .baud    (baud),
    .trmt    (send_resp),
    .tx_data (resp),
    .TX      (TX),
    .tx_done (resp_sent)
  );

  assign tmo_lim = TMO_W'(TMO_BAUDS) * TMO_W'(baud);
  assign tmo     = (state == WAIT_LO) && (tmo_cnt == tmo_lim - TMO_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_HI;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    set_rdy   = 1'b0;
    clr_hi    = 1'b0;
    case (state)
      WAIT_HI: begin
        if (rx_vld) begin
          state_nxt = WAIT_LO;
          clr_hi    = 1'b1;
        end
      end
      WAIT_LO: begin
        if (rx_vld) begin
          state_nxt = WAIT_HI;
          set_rdy   = 1'b1;
        end else if (frm_err || tmo) begin
          state_nxt = WAIT_HI;
        end
      end
      default: state_nxt = WAIT_HI;
    endcase
  end

  // cmd only moves on a completed pair; a dropped high byte leaves it intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_byte <= '0;
      cmd     <= '0;
      cmd_rdy <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (clr_hi)  hi_byte <= rx_byte;
      if (set_rdy) cmd     <= {hi_byte, rx_byte};
      if (set_rdy)                       cmd_rdy <= 1'b1;
      else if (clr_hi || clr_cmd_rdy)    cmd_rdy <= 1'b0;
      if (state == WAIT_LO && state_nxt == WAIT_LO) tmo_cnt <= tmo_cnt + TMO_ONE;
      else                                          tmo_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// tb/tb_cmd_uart_wrapper.sv - scoreboard bench for cmd_uart_wrapper
module tb_cmd_uart_wrapper;
  import la_uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;

  int checks = 0;
  int errors = 0;
  int bt = 108;
  int rdy_lat;
  int tx_frames = 0;
  bit clr_hit;
  logic [7:0]  exp_tx_q[$];
  logic [15:0] exp_cmd_q[$];

  cmd_uart_wrapper dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud        (baud),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent)
  );

  always #5 clk = ~clk;

  // Host-side receiver: every clock of every bit must carry the expected level.
  initial begin : tx_mon
    logic prev, bad, ab, have;
    logic [9:0] fr, act;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !TX) begin
        bad = 1'b0; ab = 1'b0; act = '0; have = 1'b1; fr = '1;
        if (exp_tx_q.size() == 0) begin
          have = 1'b0;
          checks++; errors++;
          $display("FAIL tx_unexpected_frame got a start bit, want none");
        end else begin
          fr = {1'b1, exp_tx_q.pop_front(), 1'b0};
        end
        for (int k = 0; k < 10 && !ab; k++) begin
          for (int c = 0; c < bt && !ab; c++) begin
            if (!(k == 0 && c == 0)) @(negedge clk);
            if (!rst_n) ab = 1'b1;
            else begin
              if (c == bt / 2) act[k] = TX;
              if (TX !== fr[k]) bad = 1'b1;
            end
          end
        end
        if (!ab && have) begin
          tx_frames++;
          checks++;
          if (bad) begin
            errors++;
            $display("FAIL tx_frame got %b want %b (or bit width wrong)", act, fr);
          end
        end
        prev = 1'b1;
      end else begin
        prev = TX;
      end
    end
  end

  initial begin : cmd_mon
    logic rdy_prev;
    logic [15:0] e;
    rdy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && cmd_rdy && !rdy_prev) begin
        checks++;
        if (exp_cmd_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected got %h want no command", cmd);
        end else begin
          e = exp_cmd_q.pop_front();
          if (cmd !== e) begin
            errors++;
            $display("FAIL cmd_scoreboard got %h want %h", cmd, e);
          end
        end
      end
      rdy_prev = cmd_rdy;
    end
  end

  task automatic set_baud(input int b);
    bt = b;
    baud = b[15:0];
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit clr_on_vld);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    rdy_lat = -1;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < bt; c++) begin
        @(negedge clk);
        RX = fr[k];
        clr_cmd_rdy = 1'b0;
        if (k == 9) begin
          if (rdy_lat < 0 && cmd_rdy) rdy_lat = c;
          if (clr_on_vld && dut.rx_vld) begin
            clr_cmd_rdy = 1'b1;
            clr_hit = 1'b1;
          end
        end
      end
    end
    @(negedge clk);
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic send_tx(input logic [7:0] b);
    @(negedge clk);
    exp_tx_q.push_back(b);
    resp = b;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_sent && n < 12 * bt) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_clr;
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (TX !== 1'b1)       begin errors++; $display("FAIL reset_tx got %b want 1", TX); end
    checks++; if (cmd !== 16'h0000)  begin errors++; $display("FAIL reset_cmd got %h want 0000", cmd); end
    checks++; if (cmd_rdy !== 1'b0)  begin errors++; $display("FAIL reset_cmd_rdy got %b want 0", cmd_rdy); end
    checks++; if (resp_sent !== 1'b0) begin errors++; $display("FAIL reset_resp_sent got %b want 0", resp_sent); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_cmd;
    exp_cmd_q.push_back(16'h4110);
    send_byte(8'h41, 1'b1, 1'b0);
    send_byte(8'h10, 1'b1, 1'b0);
    checks++;
    if (rdy_lat < 54 || rdy_lat > 60) begin
      errors++; $display("FAIL cmd_rdy_latency got %0d want 54..60 clocks into stop bit", rdy_lat);
    end
    checks++; if (cmd !== 16'h4110) begin errors++; $display("FAIL single_cmd got %h want 4110", cmd); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL single_rdy got %b want 1", cmd_rdy); end
    pulse_clr();
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL clr_cmd_rdy got %b want 0", cmd_rdy); end
  endtask

  task automatic test_response;
    int n;
    send_tx(8'hA5);
    checks++; if (TX !== 1'b0)        begin errors++; $display("FAIL tx_start_latency got %b want 0", TX); end
    checks++; if (resp_sent !== 1'b0) begin errors++; $display("FAIL resp_sent_clear got %b want 0", resp_sent); end
    wait_resp(n);
    checks++; if (n != 10 * bt) begin errors++; $display("FAIL resp_sent_latency got %0d want %0d", n, 10 * bt); end
    repeat (4) @(negedge clk);
    checks++; if (tx_frames != 1) begin errors++; $display("FAIL response_frames got %0d want 1", tx_frames); end
  endtask

  task automatic test_timeout;
    exp_cmd_q.push_back(16'h1381);
    send_byte(8'h40, 1'b1, 1'b0);
    repeat (40 * bt) @(negedge clk);
    checks++; if (cmd !== 16'h4110) begin errors++; $display("FAIL tmo_cmd_kept got %h want 4110", cmd); end
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL tmo_rdy_low got %b want 0", cmd_rdy); end
    send_byte(8'h13, 1'b1, 1'b0);
    send_byte(8'h81, 1'b1, 1'b0);
    checks++; if (cmd !== 16'h1381) begin errors++; $display("FAIL tmo_cmd got %h want 1381", cmd); end
  endtask

  task automatic test_glitch_framing;
    pulse_clr();
    @(negedge clk); RX = 1'b0;
    repeat (20) @(negedge clk);
    RX = 1'b1;
    repeat (2 * bt) @(negedge clk);
    send_byte(8'h77, 1'b0, 1'b0);
    repeat (bt) @(negedge clk);
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL glitch_no_byte got %b want 0", cmd_rdy); end
    checks++; if (cmd !== 16'h1381) begin errors++; $display("FAIL glitch_cmd_kept got %h want 1381", cmd); end
    exp_cmd_q.push_back(16'h1234);
    send_byte(8'h12, 1'b1, 1'b0);
    send_byte(8'h34, 1'b1, 1'b0);
    exp_cmd_q.push_back(16'h9ABC);
    send_byte(8'h55, 1'b1, 1'b0);
    send_byte(8'h66, 1'b0, 1'b0);
    repeat (bt) @(negedge clk);
    send_byte(8'h9A, 1'b1, 1'b0);
    send_byte(8'hBC, 1'b1, 1'b0);
    checks++; if (cmd !== 16'h9ABC) begin errors++; $display("FAIL framing_cmd got %h want 9abc", cmd); end
  endtask

  task automatic test_simultaneous;
    int n;
    pulse_clr();
    clr_hit = 1'b0;
    exp_cmd_q.push_back(16'hC35A);
    fork
      begin
        send_tx(8'h3C);
        repeat (500) @(negedge clk);
        resp = 8'hFF;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        resp = 8'h00;
        wait_resp(n);
        checks++; if (resp_sent !== 1'b1) begin errors++; $display("FAIL mid_frame_done got %b want 1", resp_sent); end
      end
      begin
        send_byte(8'hC3, 1'b1, 1'b0);
        send_byte(8'h5A, 1'b1, 1'b1);
      end
    join
    repeat (3 * bt) @(negedge clk);
    checks++; if (clr_hit !== 1'b1) begin errors++; $display("FAIL clr_coincide_hit got %b want 1", clr_hit); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL set_beats_clr got %b want 1", cmd_rdy); end
    checks++; if (tx_frames != 2)   begin errors++; $display("FAIL mid_frame_count got %0d want 2", tx_frames); end
    pulse_clr();
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL simul_clr got %b want 0", cmd_rdy); end
  endtask

  task automatic test_full_duplex;
    int f0;
    set_baud(16);
    repeat (10) @(negedge clk);
    f0 = tx_frames;
    fork
      begin
        int n;
        for (int i = 0; i < 384; i++) begin
          send_tx(8'($urandom));
          wait_resp(n);
          checks++;
          if (n != 10 * bt) begin errors++; $display("FAIL duplex_resp_%0d got %0d want %0d", i, n, 10 * bt); end
        end
      end
      begin
        repeat (100) @(negedge clk);
        exp_cmd_q.push_back(16'h8100);
        send_byte(8'h81, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
      end
    join
    repeat (4) @(negedge clk);
    checks++; if (tx_frames - f0 != 384) begin errors++; $display("FAIL duplex_frames got %0d want 384", tx_frames - f0); end
    checks++; if (cmd !== 16'h8100) begin errors++; $display("FAIL duplex_cmd got %h want 8100", cmd); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL duplex_rdy got %b want 1", cmd_rdy); end
  endtask

  task automatic test_reset_mid;
    send_tx(8'h0F);
    repeat (5 * bt + bt / 2) @(negedge clk);
    checks++; if (TX !== 1'b0) begin errors++; $display("FAIL mid_bit4_level got %b want 0", TX); end
    rst_n = 1'b0;
    #1;
    checks++; if (TX !== 1'b1)        begin errors++; $display("FAIL mid_reset_tx got %b want 1", TX); end
    checks++; if (cmd_rdy !== 1'b0)   begin errors++; $display("FAIL mid_reset_rdy got %b want 0", cmd_rdy); end
    checks++; if (resp_sent !== 1'b0) begin errors++; $display("FAIL mid_reset_sent got %b want 0", resp_sent); end
    checks++; if (cmd !== 16'h0000)   begin errors++; $display("FAIL mid_reset_cmd got %h want 0000", cmd); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL post_reset_tx got %b want 1", TX); end
  endtask

  initial begin
    baud = BAUD_921600;
    test_reset();
    test_single_cmd();
    test_response();
    test_timeout();
    test_glitch_framing();
    test_simultaneous();
    test_full_duplex();
    test_reset_mid();
    checks++; if (exp_tx_q.size() != 0)  begin errors++; $display("FAIL tx_left got %0d want 0", exp_tx_q.size()); end
    checks++; if (exp_cmd_q.size() != 0) begin errors++; $display("FAIL cmd_left got %0d want 0", exp_cmd_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_uart_wrapper.md
# cmd_uart_wrapper

Host-facing serial front end of the logic-analyzer digital core. Receives the host's UART byte stream, pairs bytes high-then-low into 16-bit commands for the command/config block, and serializes that block's 8-bit responses (acks, register reads, channel dumps) back to the host. Sits between the `RX`/`TX` pins and the command processor. Its host-side peer is the bench's master UART, which sends a 16-bit command as two bytes and collects byte responses.

## Interface
- `BAUD_W`, default 16: width of the baud divisor.
- `TMO_BAUDS`, default 32: inter-byte timeout, in bit periods, between the high and low command bytes.
- `clk`  in  1  100 MHz system clock. The only clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `baud`  in  BAUD_W  clocks per bit. `0x006C` gives 921600 baud; values below 16 are unsupported.
- `RX`  in  1  serial input from the host, asynchronous to `clk`.
- `TX`  out  1  serial output to the host. Idles high.
- `cmd`  out  16  last assembled command, `{high byte, low byte}`.
- `cmd_rdy`  out  1  sticky flag: a new `cmd` is valid.
- `clr_cmd_rdy`  in  1  clears `cmd_rdy`.
- `resp`  in  8  response byte to transmit.
- `send_resp`  in  1  one-cycle strobe that loads `resp` and starts a frame.
- `resp_sent`  out  1  sticky flag: last response frame has completed.

## Operation
- **Frame format:** 8N1, LSB first.
- **RX synchronization:** `RX` passes through a two-flop synchronizer, preset to 1 on reset.
- **RX deserializer states:**
  - IDLE: a falling edge moves to START.
  - START: wait `baud/2` clocks; a low sample goes to DATA, a high sample (glitch) returns to IDLE.
  - DATA: sample every `baud` clocks, 8 bits.
  - STOP: sample once more. High: pulse `rx_byte_vld` for one clock. Low: framing error, discard the byte, return to IDLE.
- **Command pairing FSM:**
  - WAIT_HI: a valid byte is latched as the high byte; go to WAIT_LO and clear `cmd_rdy`.
  - WAIT_LO: a valid byte updates `cmd = {hi, byte}`, sets `cmd_rdy`, returns to WAIT_HI.
  - WAIT_LO timeout: after `TMO_BAUDS*baud` clocks with no byte, drop the high byte and return to WAIT_HI. `cmd` is unchanged.
  - A framing error while in WAIT_LO also returns to WAIT_HI.
- **`cmd` update rule:** `cmd` changes only on pair completion, so a partially received command never disturbs a valid `cmd`.
- **`cmd_rdy` priority:** when set and `clr_cmd_rdy` coincide, set wins.
- **TX serializer:**
  - IDLE: `send_resp` loads `{1'b1, resp, 1'b0}` into a 10-bit shift register, clears `resp_sent`, goes to SHIFT.
  - SHIFT: one bit per `baud` clocks, 10 bits total.
  - After the last bit, set `resp_sent` and return to IDLE.
  - `send_resp` while in SHIFT is ignored and does not alter the frame in flight.
- **Full duplex:** RX and TX run independently; simultaneous operation is required.

## Timing
- **Reset values:** `TX`=1, `cmd`=0, `cmd_rdy`=0, `resp_sent`=0. Both FSMs in IDLE/WAIT_HI.
- **Reset mid-operation:** reset during a frame aborts it immediately; `TX` returns high within the reset.
- **`cmd_rdy` latency:** asserts on the clock after the low byte's stop-bit sample. That is about 9.5 bit periods after its start edge, plus 2 synchronizer clocks.
- **TX start latency:** the start bit appears on `TX` on the clock after `send_resp`.
- **TX frame length:** exactly `10*baud` clocks.
- **`resp_sent` latency:** asserts on the clock ending the stop bit. The next `send_resp` may come on that same clock.
- **Counter widths:** bit counters are 4 bits. Baud counters are `BAUD_W` bits; the half-bit count is `baud>>1`. The timeout counter is wide enough for `TMO_BAUDS*baud`.
- **Back-to-back RX:** a new start bit is accepted in the clock right after the stop sample.

## Structure
- **Shared package `la_uart_pkg`:**
  - RX state enum (IDLE/START/DATA/STOP).
  - TX state enum.
  - Pairing state enum (WAIT_HI/WAIT_LO).
  - `BAUD_921600 = 16'h006C`.
- **Sub-module `uart_rx_cfg_bd`:** the deserializer, with outputs `rx_byte`, `rx_byte_vld`, `frm_err`. It is the RX counterpart of the existing `UART_tx_cfg_bd`, which is reused for TX.
- **Top level:** the pairing FSM, timeout counter and flag logic.

## Test plan
- **Single command:** host sends `0x41`, `0x10` at baud `0x006C`. `cmd`=`0x4110` and `cmd_rdy`=1 within 2 clocks after the second stop bit. `clr_cmd_rdy` clears it.
- **Response:** `resp`=`0xA5` with `send_resp`. `TX` carries 0, 1,0,1,0,0,1,0,1, 1 with each bit `0x6C` clocks wide. `resp_sent` rises 1080 clocks after the strobe.
- **Inter-byte timeout:** send `0x40`, then idle for 40 bit periods, then send `0x13`, `0x81`. Result is `cmd`=`0x1381`; `0x40` is discarded.
- **Glitch and framing error:** a 20-clock low pulse on `RX` produces no byte. A frame with stop bit 0 produces no byte and resets pairing.
- **Simultaneous events:** `clr_cmd_rdy` on the exact cycle `cmd_rdy` sets leaves `cmd_rdy`=1. `send_resp` mid-frame leaves the frame unaltered.
- **Full duplex and reset:** 384 back-to-back TX bytes run concurrently with an RX command, and all bytes and `cmd`=`0x8100` are correct. `rst_n` low during the 5th TX data bit makes `TX`=1 and clears all flags.
